// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-RAM port arbiter.
// Holds the FSM state encoding, port identifiers and the byte-to-word index helper.
package mem_pkg;

  typedef enum logic [1:0] {
    INIT_LOAD = 2'd0,
    INIT_ZERO = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/ram_init_rom.sv
// Combinational table of the words preloaded into the data RAM after reset.
// Indices past the table return zero.
module ram_init_rom #(
  parameter int IW = 5,
  parameter int DW = 32
) (
  input  logic [IW-1:0] idx_i,
  output logic [DW-1:0] data_o
);

  // Table lookup; words 4-16 share one value and the tail spells "hello"
  always_comb begin
    case (32'(idx_i))
      32'd0:   data_o = DW'(32'd3);
      32'd1:   data_o = DW'(32'd8);
      32'd2:   data_o = DW'(32'd5);
      32'd3:   data_o = DW'(32'd2);
      32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11,
      32'd12, 32'd13, 32'd14, 32'd15, 32'd16:
               data_o = DW'(32'h32);
      32'd17:  data_o = DW'(32'h68);
      32'd18:  data_o = DW'(32'h65);
      32'd19:  data_o = DW'(32'h6C);
      32'd20:  data_o = DW'(32'h6C);
      32'd21:  data_o = DW'(32'h6F);
      default: data_o = DW'(32'd0);
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sole owner of the single-port data RAM: runs the preload/zero-fill init sequence,
// then arbitrates round-robin between the CPU port (A) and the debug/DMA port (B).
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int INIT_WORDS = 23,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [31:0]   a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [31:0]   b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          cpu_stall,
  output logic          init_done,
  output logic          err,
  output logic [31:0]   ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_LOAD = IW'(INIT_WORDS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          last_q;
  logic [31:0]   addr_q;
  logic          a_rvalid_q, b_rvalid_q, err_q, init_done_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  logic          run_s, init_s, gnt_a_s, gnt_b_s, any_gnt_s, bad_s, sel_we_s;
  logic [31:0]   sel_addr_s;
  logic [DW-1:0] sel_wdata_s, rom_data_s;

  ram_init_rom #(.IW(IW), .DW(DW)) u_rom (
    .idx_i  (idx_q),
    .data_o (rom_data_s)
  );

  // Reset is gated in so the RAM sees no enables while reset is held
  assign run_s  = (state_q == RUN) & ~reset;
  assign init_s = (state_q != RUN) & ~reset;

  assign gnt_a_s   = run_s & a_req & (~b_req | (last_q == PORT_B));
  assign gnt_b_s   = run_s & b_req & (~a_req | (last_q == PORT_A));
  assign any_gnt_s = gnt_a_s | gnt_b_s;

  assign sel_we_s    = gnt_b_s ? b_we    : a_we;
  assign sel_addr_s  = gnt_b_s ? b_addr  : a_addr;
  assign sel_wdata_s = gnt_b_s ? b_wdata : a_wdata;
  assign bad_s = (sel_addr_s[1:0] != 2'b00) | (word_idx(sel_addr_s) >= 30'(DEPTH));

  // RAM drive: init writes, granted access, or idle with the address parked
  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = {DW{1'b0}};
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (init_s) begin
      ram_addr  = 32'({idx_q, 2'b00});
      ram_wdata = (state_q == INIT_LOAD) ? rom_data_s : {DW{1'b0}};
      ram_we    = 1'b1;
    end else if (any_gnt_s) begin
      ram_addr  = sel_addr_s;
      ram_wdata = sel_wdata_s;
      ram_we    = sel_we_s & ~bad_s;
      ram_re    = ~sel_we_s & ~bad_s;
    end else begin
      ram_addr  = addr_q;
    end
  end

  // Init FSM, round-robin history and read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT_LOAD;
      idx_q       <= {IW{1'b0}};
      last_q      <= PORT_B;
      addr_q      <= 32'd0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= {DW{1'b0}};
      b_rdata_q   <= {DW{1'b0}};
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT_LOAD: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_LOAD) begin
            if (INIT_WORDS == DEPTH) begin
              state_q     <= RUN;
              idx_q       <= {IW{1'b0}};
              init_done_q <= 1'b1;
            end else begin
              state_q <= INIT_ZERO;
            end
          end
        end
        INIT_ZERO: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q     <= RUN;
            idx_q       <= {IW{1'b0}};
            init_done_q <= 1'b1;
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= INIT_LOAD;
      endcase

      if (init_s | any_gnt_s) addr_q <= ram_addr;
      if (any_gnt_s) last_q <= gnt_b_s ? PORT_B : PORT_A;

      a_rvalid_q <= gnt_a_s & ~a_we;
      b_rvalid_q <= gnt_b_s & ~b_we;
      if (gnt_a_s & ~a_we) a_rdata_q <= bad_s ? {DW{1'b0}} : ram_rdata;
      if (gnt_b_s & ~b_we) b_rdata_q <= bad_s ? {DW{1'b0}} : ram_rdata;
      err_q <= any_gnt_s & bad_s;
    end
  end

  assign a_gnt     = gnt_a_s;
  assign b_gnt     = gnt_b_s;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign err       = err_q;
  assign init_done = init_done_q;
  assign cpu_stall = a_req & ~gnt_a_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 32-word RAM attached.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        cpu_stall, init_done, err;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, combinational read
  always @(posedge clk) if (ram_we) mem[ram_addr[6:2]] <= ram_wdata;
  assign ram_rdata = mem[ram_addr[6:2]];

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .cpu_stall(cpu_stall), .init_done(init_done), .err(err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = 32'd0; b_addr = 32'd0; a_wdata = 32'd0; b_wdata = 32'd0;
    tick(); tick(); #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b exp 0", ram_we); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b exp 0", init_done); end
    checks++; if ({a_rvalid, b_rvalid, err, a_gnt, b_gnt} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b exp 00000", {a_rvalid, b_rvalid, err, a_gnt, b_gnt}); end
    checks++; if (a_rdata !== 32'd0 || b_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0/0", a_rdata, b_rdata); end
  endtask

  // Reset release with port A already requesting word 0; walks all 32 init cycles
  task automatic test_init;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++; if (ram_we !== 1'b1 || ram_addr !== 32'(i * 4)) begin errors++; $display("FAIL init_wr%0d got we=%b addr=%h exp we=1 addr=%h", i, ram_we, ram_addr, i * 4); end
      checks++; if (cpu_stall !== 1'b1 || a_gnt !== 1'b0 || init_done !== 1'b0) begin errors++; $display("FAIL init_stall%0d got stall=%b gnt=%b done=%b exp 1 0 0", i, cpu_stall, a_gnt, init_done); end
      if (i == 0) begin checks++; if (ram_wdata !== 32'd3) begin errors++; $display("FAIL init_w0 got %h exp 3", ram_wdata); end end
      if (i == 17) begin checks++; if (ram_wdata !== 32'h68) begin errors++; $display("FAIL init_w17 got %h exp 68", ram_wdata); end end
      if (i == 30) begin checks++; if (ram_wdata !== 32'd0) begin errors++; $display("FAIL init_w30 got %h exp 0", ram_wdata); end end
      tick();
    end
    #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done33 got %b exp 1", init_done); end
    checks++; if (a_gnt !== 1'b1 || cpu_stall !== 1'b0 || ram_re !== 1'b1) begin errors++; $display("FAIL first_gnt got gnt=%b stall=%b re=%b exp 1 0 1", a_gnt, cpu_stall, ram_re); end
    checks++; if (mem[17] !== 32'h68 || mem[30] !== 32'd0 || mem[22] !== 32'd0 || mem[3] !== 32'd2) begin errors++; $display("FAIL init_mem got %h %h %h %h exp 68 0 0 2", mem[17], mem[30], mem[22], mem[3]); end
    checks++; if (mem[10] !== 32'h32 || mem[21] !== 32'h6F) begin errors++; $display("FAIL init_mem2 got %h %h exp 32 6f", mem[10], mem[21]); end
    tick();
    a_req = 1'b0; #1;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'd3) begin errors++; $display("FAIL first_read got v=%b d=%h exp 1 3", a_rvalid, a_rdata); end
    tick(); #1;
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b exp 0", a_rvalid); end
  endtask

  task automatic test_write_read;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h14; a_wdata = 32'hDEAD; #1;
    checks++; if (a_gnt !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 32'hDEAD || ram_addr !== 32'h14) begin errors++; $display("FAIL wr_gnt got gnt=%b we=%b d=%h a=%h exp 1 1 dead 14", a_gnt, ram_we, ram_wdata, ram_addr); end
    tick();
    a_we = 1'b0; #1;
    checks++; if (mem[5] !== 32'hDEAD) begin errors++; $display("FAIL wr_mem got %h exp dead", mem[5]); end
    checks++; if (a_gnt !== 1'b1 || ram_re !== 1'b1 || a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_gnt got gnt=%b re=%b v=%b exp 1 1 0", a_gnt, ram_re, a_rvalid); end
    tick();
    a_req = 1'b0; #1;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD) begin errors++; $display("FAIL rd_data got v=%b d=%h exp 1 dead", a_rvalid, a_rdata); end
  endtask

  // Last grant went to A, so B wins first and grants alternate
  task automatic test_round_robin;
    logic exp_b;
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h8;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      exp_b = (k % 2 == 0);
      #1;
      checks++; if (b_gnt !== exp_b || a_gnt !== !exp_b) begin errors++; $display("FAIL rr%0d got a=%b b=%b exp a=%b b=%b", k, a_gnt, b_gnt, !exp_b, exp_b); end
      if (k > 0 && exp_b) begin checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'd5 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rr_ret%0d got av=%b ad=%h bv=%b exp 1 5 0", k, a_rvalid, a_rdata, b_rvalid); end end
      if (k > 0 && !exp_b) begin checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'd8 || a_rvalid !== 1'b0) begin errors++; $display("FAIL rr_ret%0d got bv=%b bd=%h av=%b exp 1 8 0", k, b_rvalid, b_rdata, a_rvalid); end end
      tick();
    end
    a_req = 1'b0; b_req = 1'b0; #1;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'd5 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rr_last got av=%b ad=%h bv=%b exp 1 5 0", a_rvalid, a_rdata, b_rvalid); end
    checks++; if (ram_we !== 1'b0 || ram_re !== 1'b0 || ram_addr !== 32'h8) begin errors++; $display("FAIL idle got we=%b re=%b a=%h exp 0 0 8", ram_we, ram_re, ram_addr); end
  endtask

  task automatic test_errors;
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h15; a_wdata = 32'hBAD; #1;
    checks++; if (a_gnt !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL mis_gnt got gnt=%b we=%b exp 1 0", a_gnt, ram_we); end
    tick();
    a_req = 1'b0; #1;
    checks++; if (err !== 1'b1 || mem[5] !== 32'hDEAD) begin errors++; $display("FAIL mis_err got err=%b mem5=%h exp 1 dead", err, mem[5]); end
    tick();
    a_req = 1'b1; a_addr = 32'h82; #1;
    checks++; if (a_gnt !== 1'b1 || ram_we !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL oor_wr got gnt=%b we=%b err=%b exp 1 0 0", a_gnt, ram_we, err); end
    tick();
    a_req = 1'b0; #1;
    checks++; if (err !== 1'b1 || mem[0] !== 32'd3) begin errors++; $display("FAIL oor_wr_err got err=%b mem0=%h exp 1 3", err, mem[0]); end
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h80; #1;
    checks++; if (b_gnt !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL oor_rd_gnt got gnt=%b err=%b exp 1 0", b_gnt, err); end
    tick();
    b_req = 1'b0; #1;
    checks++; if (err !== 1'b1 || b_rvalid !== 1'b1 || b_rdata !== 32'd0) begin errors++; $display("FAIL oor_rd got err=%b v=%b d=%h exp 1 1 0", err, b_rvalid, b_rdata); end
    tick(); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", err); end
  endtask

  task automatic test_reset_mid;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0; a_wdata = 32'h55;
    tick();
    a_we = 1'b0; a_addr = 32'h14; #1;
    checks++; if (mem[0] !== 32'h55 || a_gnt !== 1'b1) begin errors++; $display("FAIL mid_setup got mem0=%h gnt=%b exp 55 1", mem[0], a_gnt); end
    reset = 1'b1;
    tick();
    a_req = 1'b0; #1;
    checks++; if (a_rvalid !== 1'b0 || init_done !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL mid_rst got v=%b done=%b we=%b exp 0 0 0", a_rvalid, init_done, ram_we); end
    tick();
    reset = 1'b0; #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 32'h0 || ram_wdata !== 32'd3) begin errors++; $display("FAIL mid_restart got we=%b a=%h d=%h exp 1 0 3", ram_we, ram_addr, ram_wdata); end
    for (int i = 0; i < 32; i++) tick();
    #1;
    checks++; if (init_done !== 1'b1 || mem[0] !== 32'd3 || mem[5] !== 32'h32) begin errors++; $display("FAIL mid_reinit got done=%b mem0=%h mem5=%h exp 1 3 32", init_done, mem[0], mem[5]); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_round_robin();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
